// File: rtl/butterfly_generic_if.sv
// rtl/butterfly_generic_if.sv - sample-pair and result bus of the butterfly
interface butterfly_generic_if #(
    parameter int DATA_WIDTH = 18,
    parameter int TW_WIDTH   = 16
);
    logic                         enable;
    logic                         in_valid;
    logic                         inverse;
    logic                         ovf_clr;
    logic signed [DATA_WIDTH-1:0] a_re;
    logic signed [DATA_WIDTH-1:0] a_im;
    logic signed [DATA_WIDTH-1:0] b_re;
    logic signed [DATA_WIDTH-1:0] b_im;
    logic signed [TW_WIDTH-1:0]   tw_re;
    logic signed [TW_WIDTH-1:0]   tw_im;
    logic                         out_valid;
    logic                         ovf;
    logic signed [DATA_WIDTH-1:0] x0_re;
    logic signed [DATA_WIDTH-1:0] x0_im;
    logic signed [DATA_WIDTH-1:0] x1_re;
    logic signed [DATA_WIDTH-1:0] x1_im;

    modport master (
        output enable, in_valid, inverse, ovf_clr,
        output a_re, a_im, b_re, b_im, tw_re, tw_im,
        input  out_valid, ovf, x0_re, x0_im, x1_re, x1_im
    );

    modport slave (
        input  enable, in_valid, inverse, ovf_clr,
        input  a_re, a_im, b_re, b_im, tw_re, tw_im,
        output out_valid, ovf, x0_re, x0_im, x1_re, x1_im
    );
endinterface

// File: rtl/butterfly_generic.sv
// rtl/butterfly_generic.sv - 4-stage pipelined radix-2 complex butterfly, x0 = a + b*w, x1 = a - b*w
module butterfly_generic #(
    parameter int DATA_WIDTH  = 18,
    parameter int TW_WIDTH    = 16,
    parameter int SHIFT_PARAM = 15,
    parameter int SCALE_EN    = 0,
    parameter int SATURATE    = 1
) (
    input  logic               clk,
    input  logic               rst,
    butterfly_generic_if.slave bus
);
    localparam int PW = DATA_WIDTH + TW_WIDTH;
    localparam int SW = PW + 1;
    localparam int RW = DATA_WIDTH + 1;
    localparam int AW = DATA_WIDTH + 2;
    localparam logic signed [TW_WIDTH-1:0]   TW_MIN = {1'b1, {(TW_WIDTH-1){1'b0}}};
    localparam logic signed [TW_WIDTH-1:0]   TW_MAX = {1'b0, {(TW_WIDTH-1){1'b1}}};
    localparam logic signed [DATA_WIDTH-1:0] D_MIN  = {1'b1, {(DATA_WIDTH-1){1'b0}}};
    localparam logic signed [DATA_WIDTH-1:0] D_MAX  = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    localparam logic signed [SW-1:0]         RND    = SW'(1) << (SHIFT_PARAM - 1);

    logic                         s1_valid, s2_valid, s3_valid;
    logic signed [DATA_WIDTH-1:0] s1_a_re, s1_a_im, s1_b_re, s1_b_im;
    logic signed [TW_WIDTH-1:0]   s1_tw_re, s1_tw_im;
    logic signed [DATA_WIDTH-1:0] s2_a_re, s2_a_im, s3_a_re, s3_a_im;
    logic signed [PW-1:0]         s2_rr, s2_ii, s2_ri, s2_ir;
    logic signed [RW-1:0]         s3_p_re, s3_p_im;
    logic                         out_valid_q, ovf_q;
    logic signed [DATA_WIDTH-1:0] x0_re_q, x0_im_q, x1_re_q, x1_im_q;

    logic signed [TW_WIDTH-1:0]   tw_im_c;
    logic signed [SW-1:0]         sum_re, sum_im, sh_re, sh_im;
    logic [DATA_WIDTH:0]          c0r, c0i, c1r, c1i;
    logic                         any_sat;

    function automatic logic signed [AW-1:0] scale(input logic signed [AW-1:0] v);
        if (SCALE_EN != 0) return (v + AW'(1)) >>> 1;
        return v;
    endfunction

    // Returns {saturated_flag, value}; the flag is never raised in wrap mode.
    function automatic logic [DATA_WIDTH:0] clip(input logic signed [AW-1:0] v);
        logic fits;
        fits = (v[AW-1:DATA_WIDTH-1] == {(AW-DATA_WIDTH+1){v[AW-1]}});
        if (fits || SATURATE == 0) return {1'b0, v[DATA_WIDTH-1:0]};
        return {1'b1, (v[AW-1] ? D_MIN : D_MAX)};
    endfunction

    always_comb begin
        tw_im_c = bus.tw_im;
        if (bus.inverse) tw_im_c = (bus.tw_im == TW_MIN) ? TW_MAX : -bus.tw_im;
    end

    always_comb begin
        sum_re = SW'(s2_rr) - SW'(s2_ii) + RND;
        sum_im = SW'(s2_ri) + SW'(s2_ir) + RND;
        sh_re  = sum_re >>> SHIFT_PARAM;
        sh_im  = sum_im >>> SHIFT_PARAM;
    end

    always_comb begin
        c0r = clip(scale(AW'(s3_a_re) + AW'(s3_p_re)));
        c0i = clip(scale(AW'(s3_a_im) + AW'(s3_p_im)));
        c1r = clip(scale(AW'(s3_a_re) - AW'(s3_p_re)));
        c1i = clip(scale(AW'(s3_a_im) - AW'(s3_p_im)));
    end

    assign any_sat = c0r[DATA_WIDTH] | c0i[DATA_WIDTH] | c1r[DATA_WIDTH] | c1i[DATA_WIDTH];

    // Data stages follow enable only; in_valid rides alongside as a tag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid    <= 1'b0;
            s1_a_re     <= '0;
            s1_a_im     <= '0;
            s1_b_re     <= '0;
            s1_b_im     <= '0;
            s1_tw_re    <= '0;
            s1_tw_im    <= '0;
            s2_valid    <= 1'b0;
            s2_a_re     <= '0;
            s2_a_im     <= '0;
            s2_rr       <= '0;
            s2_ii       <= '0;
            s2_ri       <= '0;
            s2_ir       <= '0;
            s3_valid    <= 1'b0;
            s3_a_re     <= '0;
            s3_a_im     <= '0;
            s3_p_re     <= '0;
            s3_p_im     <= '0;
            out_valid_q <= 1'b0;
            x0_re_q     <= '0;
            x0_im_q     <= '0;
            x1_re_q     <= '0;
            x1_im_q     <= '0;
        end else if (bus.enable) begin
            s1_valid    <= bus.in_valid;
            s1_a_re     <= bus.a_re;
            s1_a_im     <= bus.a_im;
            s1_b_re     <= bus.b_re;
            s1_b_im     <= bus.b_im;
            s1_tw_re    <= bus.tw_re;
            s1_tw_im    <= tw_im_c;
            s2_valid    <= s1_valid;
            s2_a_re     <= s1_a_re;
            s2_a_im     <= s1_a_im;
            s2_rr       <= PW'(s1_b_re) * PW'(s1_tw_re);
            s2_ii       <= PW'(s1_b_im) * PW'(s1_tw_im);
            s2_ri       <= PW'(s1_b_re) * PW'(s1_tw_im);
            s2_ir       <= PW'(s1_b_im) * PW'(s1_tw_re);
            s3_valid    <= s2_valid;
            s3_a_re     <= s2_a_re;
            s3_a_im     <= s2_a_im;
            s3_p_re     <= sh_re[RW-1:0];
            s3_p_im     <= sh_im[RW-1:0];
            out_valid_q <= s3_valid;
            x0_re_q     <= c0r[DATA_WIDTH-1:0];
            x0_im_q     <= c0i[DATA_WIDTH-1:0];
            x1_re_q     <= c1r[DATA_WIDTH-1:0];
            x1_im_q     <= c1i[DATA_WIDTH-1:0];
        end
    end

    // Clear is honoured even while stalled; a coincident set takes priority.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_q <= 1'b0;
        end else if (bus.enable && s3_valid && any_sat) begin
            ovf_q <= 1'b1;
        end else if (bus.ovf_clr) begin
            ovf_q <= 1'b0;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.ovf       = ovf_q;
    assign bus.x0_re     = x0_re_q;
    assign bus.x0_im     = x0_im_q;
    assign bus.x1_re     = x1_re_q;
    assign bus.x1_im     = x1_im_q;
endmodule

// File: tb/tb_butterfly_generic.sv
// tb/tb_butterfly_generic.sv - bench for butterfly_generic in saturating, scaled and wrapping builds
module tb_butterfly_generic;
    localparam int DW = 18;
    localparam int TW = 16;
    localparam int SH = 15;
    localparam int NI = 3;
    localparam longint DMAX = (longint'(1) << (DW - 1)) - 1;
    localparam longint DMIN = -(longint'(1) << (DW - 1));

    typedef struct {
        longint a_re, a_im, b_re, b_im, tw_re, tw_im;
        bit     inverse;
    } in_t;
    typedef struct {
        longint x0_re, x0_im, x1_re, x1_im;
        bit     ov;
    } res_t;
    typedef struct {
        bit  valid;
        in_t s;
    } slot_t;
    typedef struct {
        string  name;
        in_t    s;
        int     inst;
        longint x0_re, x0_im, x1_re, x1_im;
        bit     ovf;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic drv_en = 1'b0, drv_vld = 1'b0, drv_inv = 1'b0, drv_clr = 1'b0;
    logic signed [DW-1:0] drv_a_re = '0, drv_a_im = '0, drv_b_re = '0, drv_b_im = '0;
    logic signed [TW-1:0] drv_tw_re = '0, drv_tw_im = '0;

    logic                 o_valid [NI];
    logic                 o_ovf   [NI];
    logic signed [DW-1:0] o_x0r   [NI];
    logic signed [DW-1:0] o_x0i   [NI];
    logic signed [DW-1:0] o_x1r   [NI];
    logic signed [DW-1:0] o_x1i   [NI];

    // Instance 0: defaults; 1: SCALE_EN=1; 2: SATURATE=0.
    genvar g;
    generate
        for (g = 0; g < NI; g++) begin : g_dut
            butterfly_generic_if #(.DATA_WIDTH(DW), .TW_WIDTH(TW)) bus ();
            butterfly_generic #(
                .DATA_WIDTH(DW), .TW_WIDTH(TW), .SHIFT_PARAM(SH),
                .SCALE_EN(g == 1 ? 1 : 0), .SATURATE(g == 2 ? 0 : 1)
            ) u_dut (
                .clk(clk),
                .rst(rst),
                .bus(bus)
            );
            assign bus.enable   = drv_en;
            assign bus.in_valid = drv_vld;
            assign bus.inverse  = drv_inv;
            assign bus.ovf_clr  = drv_clr;
            assign bus.a_re     = drv_a_re;
            assign bus.a_im     = drv_a_im;
            assign bus.b_re     = drv_b_re;
            assign bus.b_im     = drv_b_im;
            assign bus.tw_re    = drv_tw_re;
            assign bus.tw_im    = drv_tw_im;
            assign o_valid[g]   = bus.out_valid;
            assign o_ovf[g]     = bus.ovf;
            assign o_x0r[g]     = bus.x0_re;
            assign o_x0i[g]     = bus.x0_im;
            assign o_x1r[g]     = bus.x1_re;
            assign o_x1i[g]     = bus.x1_im;
        end
    endgenerate

    int    checks = 0;
    int    errors = 0;
    slot_t q[$];
    bit    cur_valid = 1'b0;
    in_t   cur_in;
    bit    m_ovf[NI];

    function automatic longint wrapw(longint v, int w);
        longint m = longint'(1) << w;
        return ((v + (m >>> 1)) & (m - 1)) - (m >>> 1);
    endfunction

    // Arithmetic statement of the butterfly: exact products, round-half-up rescale,
    // then optional halving and clamp/wrap to the output width.
    function automatic res_t model(in_t s, int inst);
        res_t   r;
        longint wi, pr, pi, half;
        longint v[4];
        half = longint'(1) << (SH - 1);
        wi = s.tw_im;
        if (s.inverse) wi = (s.tw_im == -(longint'(1) << (TW - 1))) ? (longint'(1) << (TW - 1)) - 1 : -s.tw_im;
        pr = wrapw((s.b_re * s.tw_re - s.b_im * wi + half) >>> SH, DW + 1);
        pi = wrapw((s.b_re * wi + s.b_im * s.tw_re + half) >>> SH, DW + 1);
        v[0] = s.a_re + pr;
        v[1] = s.a_im + pi;
        v[2] = s.a_re - pr;
        v[3] = s.a_im - pi;
        r.ov = 1'b0;
        for (int k = 0; k < 4; k++) begin
            if (inst == 1) v[k] = (v[k] + 1) >>> 1;
            if (inst == 2) v[k] = wrapw(v[k], DW);
            else if (v[k] > DMAX) begin v[k] = DMAX; r.ov = 1'b1; end
            else if (v[k] < DMIN) begin v[k] = DMIN; r.ov = 1'b1; end
        end
        r.x0_re = v[0];
        r.x0_im = v[1];
        r.x1_re = v[2];
        r.x1_im = v[3];
        return r;
    endfunction

    function automatic longint rnd_v(int w);
        longint mx = (longint'(1) << (w - 1)) - 1;
        int     sel = $urandom_range(0, 7);
        if (sel == 0) return mx;
        if (sel == 1) return -mx - 1;
        return longint'($urandom_range(0, 32'(2 * mx + 1))) - mx - 1;
    endfunction

    function automatic in_t rand_in();
        in_t s;
        s.a_re    = rnd_v(DW);
        s.a_im    = rnd_v(DW);
        s.b_re    = rnd_v(DW);
        s.b_im    = rnd_v(DW);
        s.tw_re   = rnd_v(TW);
        s.tw_im   = rnd_v(TW);
        s.inverse = ($urandom_range(0, 1) == 1);
        return s;
    endfunction

    task automatic chk(input string name, input logic signed [63:0] act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic check_all();
        res_t r;
        for (int i = 0; i < NI; i++) begin
            chk($sformatf("u%0d.out_valid", i), o_valid[i], longint'(cur_valid));
            if (cur_valid) begin
                r = model(cur_in, i);
                chk($sformatf("u%0d.x0_re", i), o_x0r[i], r.x0_re);
                chk($sformatf("u%0d.x0_im", i), o_x0i[i], r.x0_im);
                chk($sformatf("u%0d.x1_re", i), o_x1r[i], r.x1_re);
                chk($sformatf("u%0d.x1_im", i), o_x1i[i], r.x1_im);
            end
            chk($sformatf("u%0d.ovf", i), o_ovf[i], longint'(m_ovf[i]));
        end
    endtask

    task automatic check_zero(input string tag);
        for (int i = 0; i < NI; i++) begin
            chk($sformatf("%s.u%0d.out_valid", tag, i), o_valid[i], 0);
            chk($sformatf("%s.u%0d.ovf", tag, i), o_ovf[i], 0);
            chk($sformatf("%s.u%0d.x0_re", tag, i), o_x0r[i], 0);
            chk($sformatf("%s.u%0d.x0_im", tag, i), o_x0i[i], 0);
            chk($sformatf("%s.u%0d.x1_re", tag, i), o_x1r[i], 0);
            chk($sformatf("%s.u%0d.x1_im", tag, i), o_x1i[i], 0);
        end
    endtask

    task automatic model_reset();
        q.delete();
        cur_valid = 1'b0;
        for (int i = 0; i < NI; i++) m_ovf[i] = 1'b0;
    endtask

    // One clock: drive, advance the latency model on enabled edges, compare.
    task automatic step(input in_t s, input bit en, input bit vld, input bit clr);
        slot_t n;
        drv_a_re  = DW'(s.a_re);
        drv_a_im  = DW'(s.a_im);
        drv_b_re  = DW'(s.b_re);
        drv_b_im  = DW'(s.b_im);
        drv_tw_re = TW'(s.tw_re);
        drv_tw_im = TW'(s.tw_im);
        drv_inv   = s.inverse;
        drv_en    = en;
        drv_vld   = vld;
        drv_clr   = clr;
        @(posedge clk);
        #1;
        if (en) begin
            n.valid = vld;
            n.s     = s;
            q.push_back(n);
            if (q.size() == 4) begin
                n = q.pop_front();
                cur_valid = n.valid;
                cur_in    = n.s;
            end else begin
                cur_valid = 1'b0;
            end
        end
        for (int i = 0; i < NI; i++) begin
            if (en && cur_valid && model(cur_in, i).ov) m_ovf[i] = 1'b1;
            else if (clr) m_ovf[i] = 1'b0;
        end
        check_all();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at time %0t", $time);
        $fatal(1);
    end

    initial begin
        vec_t vecs[5];
        in_t  s;
        int   inst, seen, nsent;
        bit   en;

        vecs[0] = '{"unity_half", '{1000, 0, 2000, 0, 16384, 0, 1'b0}, 0, 2000, 0, 0, 0, 1'b0};
        vecs[1] = '{"inverse_j", '{0, 0, 2000, 0, 0, 16384, 1'b1}, 0, 0, -1000, 0, 1000, 1'b0};
        vecs[2] = '{"scale_pos", '{3, 0, 0, 0, 16384, 0, 1'b0}, 1, 2, 0, 2, 0, 1'b0};
        vecs[3] = '{"scale_neg", '{-3, 0, 0, 0, 16384, 0, 1'b0}, 1, -1, 0, -1, 0, 1'b0};
        vecs[4] = '{"saturate", '{131071, 0, 131071, 0, 32767, 0, 1'b0}, 0, 131071, 0, 4, 0, 1'b1};

        rst = 1'b0;
        #1 rst = 1'b1;
        #1;
        check_zero("reset");
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        s = '{0, 0, 0, 0, 0, 0, 1'b0};
        for (int k = 0; k < 2; k++) step(s, 1'b1, 1'b0, 1'b0);

        for (int v = 0; v < 5; v++) begin
            step(vecs[v].s, 1'b1, 1'b1, 1'b0);
            for (int k = 0; k < 3; k++) step(vecs[v].s, 1'b1, 1'b0, 1'b0);
            inst = vecs[v].inst;
            chk({vecs[v].name, ".out_valid"}, o_valid[inst], 1);
            chk({vecs[v].name, ".x0_re"}, o_x0r[inst], vecs[v].x0_re);
            chk({vecs[v].name, ".x0_im"}, o_x0i[inst], vecs[v].x0_im);
            chk({vecs[v].name, ".x1_re"}, o_x1r[inst], vecs[v].x1_re);
            chk({vecs[v].name, ".x1_im"}, o_x1i[inst], vecs[v].x1_im);
            chk({vecs[v].name, ".ovf"}, o_ovf[inst], longint'(vecs[v].ovf));
        end

        for (int k = 0; k < 3; k++) step(vecs[4].s, 1'b1, 1'b0, 1'b0);
        chk("ovf_sticky", o_ovf[0], 1);
        step(vecs[4].s, 1'b0, 1'b0, 1'b1);
        chk("ovf_clr_while_stalled", o_ovf[0], 0);

        step(vecs[4].s, 1'b1, 1'b1, 1'b0);
        for (int k = 0; k < 2; k++) step(vecs[4].s, 1'b1, 1'b0, 1'b0);
        step(vecs[4].s, 1'b1, 1'b0, 1'b1);
        chk("ovf_set_beats_clr", o_ovf[0], 1);
        step(vecs[4].s, 1'b1, 1'b0, 1'b1);
        chk("ovf_clr_after_set", o_ovf[0], 0);

        seen  = 0;
        nsent = 0;
        for (int k = 0; k < 13; k++) begin
            en = !(k >= 4 && k < 7);
            step(rand_in(), en, en && (nsent < 6), 1'b0);
            if (en && nsent < 6) nsent++;
            if (en && o_valid[0]) seen++;
        end
        chk("stall_burst_count", seen, 6);

        for (int k = 0; k < 5; k++) step(rand_in(), 1'b1, 1'b1, 1'b0);
        #2 rst = 1'b1;
        #1;
        check_zero("async_reset");
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 6; k++) step(rand_in(), 1'b1, 1'b0, 1'b0);

        for (int k = 0; k < 400; k++) begin
            step(rand_in(), $urandom_range(0, 4) != 0, $urandom_range(0, 2) != 0,
                 $urandom_range(0, 15) == 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/butterfly_generic.md
BUTTERFLY_GENERIC -- requirements
Module: butterfly_generic

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 18: signed width of every data input and output.
REQ-002 SHALL have parameter TW_WIDTH, default 16: signed twiddle width, format Q1.(TW_WIDTH-1).
REQ-003 SHALL have parameter SHIFT_PARAM, default 15 (= TW_WIDTH-1): product rescale shift.
REQ-004 SHALL have parameter SCALE_EN, default 0: when 1, both outputs are divided by 2 with rounding.
REQ-005 SHALL have parameter SATURATE, default 1: when 1, outputs saturate; when 0, outputs wrap and no overflow is flagged.
REQ-006 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-007 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-008 SHALL have port enable, input, 1 bit: pipeline advance; 0 freezes every register.
REQ-009 SHALL have port in_valid, input, 1 bit: input sample pair valid.
REQ-010 SHALL have port inverse, input, 1 bit: per-sample flag that conjugates the twiddle.
REQ-011 SHALL have ports a_re, a_im, b_re, b_im, inputs, DATA_WIDTH signed: operands a and b.
REQ-012 SHALL have ports tw_re, tw_im, inputs, TW_WIDTH signed: twiddle w, sampled per input.
REQ-013 SHALL have port ovf_clr, input, 1 bit: synchronous clear of the sticky overflow flag.
REQ-014 SHALL have port out_valid, output, 1 bit: output pair valid.
REQ-015 SHALL have ports x0_re, x0_im, x1_re, x1_im, outputs, DATA_WIDTH signed: x0 = a + b*w, x1 = a - b*w.
REQ-016 SHALL have port ovf, output, 1 bit: sticky saturation flag.

Function
REQ-017 SHALL use a 4-stage pipeline; an input accepted on an enabled edge appears on the outputs after exactly 4 enabled edges, with out_valid equal to the delayed in_valid.
REQ-018 Stage 1 SHALL register the inputs; with inverse=1, tw_im SHALL be negated, and a negated most-negative value SHALL saturate to the most-positive value.
REQ-019 Stage 2 SHALL form the four full-precision products b_re*tw_re, b_im*tw_im, b_re*tw_im and b_im*tw_re, each DATA_WIDTH+TW_WIDTH bits wide.
REQ-020 Stage 3 SHALL compute p_re = br*wr - bi*wi and p_im = br*wi + bi*wr at DATA_WIDTH+TW_WIDTH+1 bits, add 1<<(SHIFT_PARAM-1), then arithmetic-shift right by SHIFT_PARAM, keeping DATA_WIDTH+1 bits.
REQ-021 Stage 4 SHALL compute a±p at DATA_WIDTH+2 bits; if SCALE_EN=1, it SHALL add 1 and arithmetic-shift right by 1; the result SHALL then be saturated (or wrapped) to DATA_WIDTH.
REQ-022 Operand a SHALL be delay-matched through stages 1-3.
REQ-023 With enable=0, all data, valid and ovf registers SHALL hold, and outputs SHALL remain stable.
REQ-024 Data registers SHALL update regardless of in_valid; only out_valid qualifies the outputs.
REQ-025 ovf SHALL be set on any enabled stage-4 edge where a valid result saturates in any of its four components.
REQ-026 ovf_clr SHALL clear ovf on the next edge regardless of enable; if a set and a clear coincide, the set SHALL win.

Reset
REQ-027 While rst=1, all pipeline registers, all outputs, out_valid and ovf SHALL be 0 immediately, without waiting for a clock edge.
REQ-028 After rst deasserts, no pre-reset in-flight sample SHALL produce out_valid=1; the first valid output SHALL follow the first post-reset in_valid by exactly 4 enabled edges.

Verification
REQ-029 SHALL cover: a=(1000,0), b=(2000,0), w=(16384,0), inverse=0 -> 4 edges later out_valid=1, x0=(2000,0), x1=(0,0), ovf=0.
REQ-030 SHALL cover: a=(0,0), b=(2000,0), w=(0,16384), inverse=1 -> x0=(0,-1000), x1=(0,1000).
REQ-031 SHALL cover saturation: a=(131071,0), b=(131071,0), w=(32767,0) -> x0=(131071,0), x1=(4,0), ovf=1; ovf stays 1 until ovf_clr is pulsed, then becomes 0.
REQ-032 SHALL cover stall: a burst of 6 valid samples with enable low for 3 cycles mid-burst -> no sample lost or duplicated, each sample's latency is 4 enabled edges, and outputs are frozen during the stall.
REQ-033 SHALL cover reset mid-operation: rst pulsed with 3 samples in flight -> out_valid=0 and all outputs 0 asynchronously, and no stale out_valid after release.
REQ-034 SHALL cover SCALE_EN=1, b=0: a=(3,0) gives x0=(2,0); a=(-3,0) gives x0=(-1,0).
